// File: rtl/smi_pkg.sv
// smi_pkg: shared SMI constants and helpers (eofc width, eofc clamp, clog2)
package smi_pkg;
   localparam int SMI_EOFC_WIDTH = 8;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic logic [SMI_EOFC_WIDTH-1:0] eofc_clamp(input logic [SMI_EOFC_WIDTH-1:0] e,
                                                            input logic [SMI_EOFC_WIDTH-1:0] max);
      return (e > max) ? max : e;
   endfunction
endpackage

// File: rtl/smi_flit_reg_slice.sv
// smi_flit_reg_slice: SMI input register slice (ready/eofc/data) with last flag
//   clk, srst        : clock, sync active-high reset (clears ready_q, last_q)
//   halt             : hold all registers this cycle
//   ready/eofc/data  : incoming flit
//   ready_q/last_q/eofc_q/data_q : registered flit, eofc clamped to MaxEofc
module smi_flit_reg_slice
   import smi_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int MaxEofc   = 4
) (
   input  logic                      clk,
   input  logic                      srst,
   input  logic                      halt,
   input  logic                      ready,
   input  logic [SMI_EOFC_WIDTH-1:0] eofc,
   input  logic [DataWidth-1:0]      data,
   output logic                      ready_q,
   output logic                      last_q,
   output logic [SMI_EOFC_WIDTH-1:0] eofc_q,
   output logic [DataWidth-1:0]      data_q
);
   always_ff @(posedge clk)
      if (srst) begin
         ready_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (!halt) begin
         ready_q <= ready;
         last_q  <= eofc != '0;
      end
   always_ff @(posedge clk)
      if (!halt) begin
         data_q <= data;
         eofc_q <= eofc_clamp(eofc, SMI_EOFC_WIDTH'(MaxEofc));
      end
endmodule

// File: rtl/smi_flit_scale_up.sv
// smi_flit_scale_up: packs ScaleFactor input flits into one wide SMI flit, frame preserving
//   clk, srst                          : clock, sync active-high reset
//   smiInReady/smiInEofc/smiInData     : narrow input flit, smiInStop backpressure out
//   smiOutReady/smiOutEofc/smiOutData  : wide output flit, smiOutStop backpressure in
module smi_flit_scale_up
   import smi_pkg::*;
#(
   parameter int FlitWidth   = 4,
   parameter int ScaleFactor = 4
) (
   input  logic                                clk,
   input  logic                                srst,
   input  logic                                smiInReady,
   input  logic [SMI_EOFC_WIDTH-1:0]           smiInEofc,
   input  logic [FlitWidth*8-1:0]              smiInData,
   output logic                                smiInStop,
   output logic                                smiOutReady,
   output logic [SMI_EOFC_WIDTH-1:0]           smiOutEofc,
   output logic [FlitWidth*ScaleFactor*8-1:0]  smiOutData,
   input  logic                                smiOutStop
);
   localparam int LW = clog2(ScaleFactor);
   localparam int LANE_W = FlitWidth * 8;
   logic                      halt;
   logic                      in_ready_q;
   logic                      in_last_q;
   logic [SMI_EOFC_WIDTH-1:0] in_eofc_q;
   logic [LANE_W-1:0]         in_data_q;
   logic                      out_ready_q;
   logic [LW-1:0]             lane_q;
   logic [SMI_EOFC_WIDTH-1:0] eofc_q;
   logic [LANE_W-1:0]         lanes [ScaleFactor];
   assign halt        = smiOutReady & smiOutStop;
   // only a full slice stalls; an empty one absorbs one flit during a stall
   assign smiInStop   = in_ready_q & halt;
   assign smiOutReady = out_ready_q;
   assign smiOutEofc  = eofc_q;
   smi_flit_reg_slice #(.DataWidth(LANE_W), .MaxEofc(FlitWidth)) u_in (
      .clk    (clk),
      .srst   (srst),
      .halt   (smiInStop),
      .ready  (smiInReady),
      .eofc   (smiInEofc),
      .data   (smiInData),
      .ready_q(in_ready_q),
      .last_q (in_last_q),
      .eofc_q (in_eofc_q),
      .data_q (in_data_q)
   );
   always_ff @(posedge clk)
      if (srst) begin
         out_ready_q <= 1'b0;
         lane_q      <= '0;
      end else if (!halt) begin
         if (!in_ready_q)
            out_ready_q <= 1'b0;
         else if (in_last_q || lane_q == LW'(ScaleFactor - 1)) begin
            out_ready_q <= 1'b1;
            lane_q      <= '0;
         end else begin
            out_ready_q <= 1'b0;
            lane_q      <= lane_q + 1'b1;
         end
      end
   // a write into lane 0 starts a new output flit, so stale upper lanes are zeroed
   always_ff @(posedge clk)
      if (!srst && !halt && in_ready_q) begin
         for (int i = 0; i < ScaleFactor; i++)
            if (LW'(i) == lane_q) lanes[i] <= in_data_q;
            else if (lane_q == '0) lanes[i] <= '0;
         eofc_q <= in_last_q ? SMI_EOFC_WIDTH'(lane_q) * SMI_EOFC_WIDTH'(FlitWidth) + in_eofc_q : '0;
      end
   for (genvar g = 0; g < ScaleFactor; g++) begin : g_out
      assign smiOutData[g*LANE_W +: LANE_W] = lanes[g];
   end
endmodule

// File: tb/tb_smi_flit_scale_up.sv
// tb_smi_flit_scale_up: directed self-checking bench for smi_flit_scale_up (FlitWidth=4, ScaleFactor=4)
module tb_smi_flit_scale_up;
   logic         clk;
   logic         srst;
   logic         smiInReady;
   logic [7:0]   smiInEofc;
   logic [31:0]  smiInData;
   logic         smiInStop;
   logic         smiOutReady;
   logic [7:0]   smiOutEofc;
   logic [127:0] smiOutData;
   logic         smiOutStop;
   int           checks;
   int           errors;
   logic [127:0] qd[$];
   logic [7:0]   qe[$];
   logic         stall_on;
   logic [15:0]  pat;
   int           pidx;

   smi_flit_scale_up #(.FlitWidth(4), .ScaleFactor(4)) dut (
      .clk        (clk),
      .srst       (srst),
      .smiInReady (smiInReady),
      .smiInEofc  (smiInEofc),
      .smiInData  (smiInData),
      .smiInStop  (smiInStop),
      .smiOutReady(smiOutReady),
      .smiOutEofc (smiOutEofc),
      .smiOutData (smiOutData),
      .smiOutStop (smiOutStop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk)
      if (smiOutReady === 1'b1 && smiOutStop === 1'b0) begin
         qd.push_back(smiOutData);
         qe.push_back(smiOutEofc);
      end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic outchk(input string tag, input int i, input logic [127:0] d, input logic [7:0] e);
      chk({tag, "_data"}, (qd.size() > i) ? qd[i] : 'x, d);
      chk({tag, "_eofc"}, (qe.size() > i) ? 128'(qe[i]) : 'x, 128'(e));
   endtask

   task automatic send(input logic [31:0] d, input logic [7:0] e);
      logic taken;
      smiInReady = 1'b1;
      smiInData  = d;
      smiInEofc  = e;
      for (int n = 0; n < 50; n++) begin
         #1;
         taken = !smiInStop;
         @(posedge clk);
         #1;
         if (taken) return;
      end
      checks++;
      errors++;
      $error("FAIL send_timeout observed=stalled expected=accepted");
   endtask

   task automatic idle();
      smiInReady = 1'b0;
      smiInEofc  = '0;
      smiInData  = '0;
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic flush();
      qd.delete();
      qe.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      stall_on = 1'b0;
      pat = 16'b1011_0011_1000_1101;
      pidx = 0;
      srst = 1'b1;
      smiOutStop = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      srst = 1'b0;
      chk("reset_out_ready", 128'(smiOutReady), 128'd0);
      chk("reset_in_stop", 128'(smiInStop), 128'd0);

      // full frame with latency check
      send(32'h11111111, 0);
      send(32'h22222222, 0);
      send(32'h33333333, 0);
      send(32'h44444444, 4);
      idle();
      chk("full_not_yet", 128'(smiOutReady), 128'd0);
      @(posedge clk);
      #1;
      chk("full_ready_2cyc", 128'(smiOutReady), 128'd1);
      drain();
      chk("full_count", 128'(qd.size()), 128'd1);
      outchk("full", 0, 128'h44444444_33333333_22222222_11111111, 8'd16);
      flush();

      // six-flit frame
      send(32'hAAAAAAAA, 0);
      send(32'hBBBBBBBB, 0);
      send(32'hCCCCCCCC, 0);
      send(32'hDDDDDDDD, 0);
      send(32'hEEEEEEEE, 0);
      send(32'hFFFFFFFF, 2);
      idle();
      drain();
      chk("six_count", 128'(qd.size()), 128'd2);
      outchk("six0", 0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 8'd0);
      outchk("six1", 1, 128'h00000000_00000000_FFFFFFFF_EEEEEEEE, 8'd6);
      flush();

      // single-flit frame followed directly by a two-flit frame
      send(32'hDEADBEEF, 3);
      send(32'h01010101, 0);
      send(32'h02020202, 4);
      idle();
      drain();
      chk("single_count", 128'(qd.size()), 128'd2);
      outchk("single", 0, 128'h00000000_00000000_00000000_DEADBEEF, 8'd3);
      outchk("next_lane0", 1, 128'h00000000_00000000_02020202_01010101, 8'd8);
      flush();

      // backpressure: output held while stopped, slice fills
      smiOutStop = 1'b1;
      send(32'h50505050, 0);
      send(32'h60606060, 0);
      send(32'h70707070, 0);
      send(32'h80808080, 4);
      send(32'h90909090, 4);
      smiInReady = 1'b1;
      smiInData  = 32'hA1A1A1A1;
      smiInEofc  = 8'd4;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_stop", 128'(smiInStop), 128'd1);
         chk("bp_out_ready", 128'(smiOutReady), 128'd1);
         chk("bp_out_data", smiOutData, 128'h80808080_70707070_60606060_50505050);
         @(posedge clk);
         #1;
      end
      smiOutStop = 1'b0;
      send(32'hA1A1A1A1, 4);
      idle();
      drain();
      chk("bp_count", 128'(qd.size()), 128'd3);
      outchk("bp0", 0, 128'h80808080_70707070_60606060_50505050, 8'd16);
      outchk("bp1", 1, 128'h00000000_00000000_00000000_90909090, 8'd4);
      outchk("bp2", 2, 128'h00000000_00000000_00000000_A1A1A1A1, 8'd4);
      flush();

      // three frames under a fixed pseudo-random stall pattern
      stall_on = 1'b1;
      fork
         begin
            send(32'hC0000001, 0);
            send(32'hC0000002, 0);
            send(32'hC0000003, 0);
            send(32'hC0000004, 0);
            send(32'hC0000005, 4);
            send(32'hD0000001, 0);
            send(32'hD0000002, 0);
            send(32'hD0000003, 1);
            send(32'hE0000001, 0);
            send(32'hE0000002, 0);
            send(32'hE0000003, 0);
            send(32'hE0000004, 3);
            idle();
            stall_on = 1'b0;
         end
         begin
            while (stall_on) begin
               @(posedge clk);
               #1;
               smiOutStop = pat[pidx];
               pidx = (pidx + 1) % 16;
            end
            smiOutStop = 1'b0;
         end
      join
      repeat (3) drain();
      chk("stall_count", 128'(qd.size()), 128'd4);
      outchk("stall0", 0, 128'hC0000004_C0000003_C0000002_C0000001, 8'd0);
      outchk("stall1", 1, 128'h00000000_00000000_00000000_C0000005, 8'd4);
      outchk("stall2", 2, 128'h00000000_D0000003_D0000002_D0000001, 8'd9);
      outchk("stall3", 3, 128'hE0000004_E0000003_E0000002_E0000001, 8'd15);
      flush();

      // reset mid-frame discards partial data
      send(32'h0BADF00D, 0);
      send(32'h0BADF00E, 0);
      idle();
      srst = 1'b1;
      @(posedge clk);
      #1;
      srst = 1'b0;
      send(32'h12345678, 0);
      send(32'h23456789, 0);
      send(32'h3456789A, 0);
      send(32'h456789AB, 4);
      idle();
      drain();
      chk("rst_count", 128'(qd.size()), 128'd1);
      outchk("rst", 0, 128'h456789AB_3456789A_23456789_12345678, 8'd16);
      flush();

      // eofc clamp: 9 clamps to 4, in lane 1 gives 8
      send(32'h10101010, 0);
      send(32'h20202020, 9);
      idle();
      drain();
      chk("clamp_count", 128'(qd.size()), 128'd1);
      outchk("clamp", 0, 128'h00000000_00000000_20202020_10101010, 8'd8);
      flush();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
